// File: rtl/lowx_mem_arbiter.sv
// lowx_mem_arbiter
// ----------------
// Arbiter and sequencer between the icache refill port, the dcache
// refill/writeback port and one downstream memory port. Only one
// transaction is in flight at a time: IDLE grants a requester, REQ
// presents the latched request downstream until it is accepted, and WAIT
// collects the single response and routes it back to the owner.
//
// Build option:
//   LOWX_ARB_STARVE_GUARD_EN - when defined, a saturating counter tracks
//   dcache grants made while the icache is waiting. Once it reaches
//   STARVE_LIMIT, the icache wins the next arbitration. When undefined,
//   the dcache always has priority.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 drop the pending response; blocks a grant in IDLE
//   ic_req_* / ic_rsp_*     icache request (read-only) and response
//   dc_req_* / dc_rsp_*     dcache request (read/write, uncached) and response
//   mem_req_* / mem_rsp_*   downstream valid/ready request and response
module lowx_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int BLK_SIZE     = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                ic_req_valid_i,
  input  logic [XLEN-1:0]     ic_req_addr_i,
  output logic                ic_req_ready_o,
  output logic                ic_rsp_valid_o,
  output logic [BLK_SIZE-1:0] ic_rsp_data_o,
  input  logic                dc_req_valid_i,
  input  logic [XLEN-1:0]     dc_req_addr_i,
  input  logic                dc_req_rw_i,
  input  logic                dc_req_uncached_i,
  input  logic [BLK_SIZE-1:0] dc_req_data_i,
  output logic                dc_req_ready_o,
  output logic                dc_rsp_valid_o,
  output logic [BLK_SIZE-1:0] dc_rsp_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_rw_o,
  output logic                mem_req_uncached_o,
  output logic [BLK_SIZE-1:0] mem_req_data_o,
  input  logic                mem_rsp_valid_i,
  input  logic [BLK_SIZE-1:0] mem_rsp_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state;
  logic   owner_ic;   // 1 = transaction in flight belongs to the icache
  logic   drop;       // a flush hit this transaction; suppress its response
  logic   force_ic;   // starvation guard overrides dcache priority
  logic   grant_ic;
  logic   grant_dc;

`ifdef LOWX_ARB_STARVE_GUARD_EN
  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign force_ic = ic_req_valid_i && (starve_cnt == LIMIT);

  // Counts dcache grants that overtook a waiting icache. Any grant made
  // without the icache waiting resets the streak.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (grant_ic) begin
      starve_cnt <= '0;
    end else if (grant_dc) begin
      if (!ic_req_valid_i)          starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_ic = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE && !flush_i) begin
      if (ic_req_valid_i && (force_ic || !dc_req_valid_i)) grant_ic = 1'b1;
      else if (dc_req_valid_i)                             grant_dc = 1'b1;
    end
  end

  // Acceptance is combinational so a requester sees ready in its grant cycle.
  assign ic_req_ready_o = grant_ic;
  assign dc_req_ready_o = grant_dc;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of ordering.
  // The data registers are reset as well because they are visible outputs
  // that must read zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state              <= IDLE;
      owner_ic           <= 1'b0;
      drop               <= 1'b0;
      mem_req_valid_o    <= 1'b0;
      mem_req_addr_o     <= '0;
      mem_req_rw_o       <= 1'b0;
      mem_req_uncached_o <= 1'b0;
      mem_req_data_o     <= '0;
      ic_rsp_valid_o     <= 1'b0;
      ic_rsp_data_o      <= '0;
      dc_rsp_valid_o     <= 1'b0;
      dc_rsp_data_o      <= '0;
    end else begin
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic) begin
            owner_ic           <= 1'b1;
            mem_req_valid_o    <= 1'b1;
            mem_req_addr_o     <= ic_req_addr_i;
            mem_req_rw_o       <= 1'b0;
            mem_req_uncached_o <= 1'b0;
            mem_req_data_o     <= '0;
            state              <= REQ;
          end else if (grant_dc) begin
            owner_ic           <= 1'b0;
            mem_req_valid_o    <= 1'b1;
            mem_req_addr_o     <= dc_req_addr_i;
            mem_req_rw_o       <= dc_req_rw_i;
            mem_req_uncached_o <= dc_req_uncached_i;
            mem_req_data_o     <= dc_req_data_i;
            state              <= REQ;
          end
        end
        REQ: begin
          if (flush_i) drop <= 1'b1;
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            // A flush arriving with the response still cancels delivery.
            if (owner_ic) begin
              ic_rsp_data_o  <= mem_rsp_data_i;
              ic_rsp_valid_o <= !(drop || flush_i);
            end else begin
              dc_rsp_data_o  <= mem_rsp_data_i;
              dc_rsp_valid_o <= !(drop || flush_i);
            end
            drop  <= 1'b0;
            state <= IDLE;
          end else if (flush_i) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Testbench for lowx_mem_arbiter. A transaction-level model tracks whether
// a request is in flight, whether it is still offered downstream, who owns
// it and whether a flush cancelled it; a compare process checks the DUT
// against it on every falling edge. Directed sequences add literal checks.
// Works with or without LOWX_ARB_STARVE_GUARD_EN defined.
module tb_lowx_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int BLK   = 128;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            ic_req_valid = 1'b0;
  logic [XLEN-1:0] ic_req_addr = '0;
  logic            ic_req_ready;
  logic            ic_rsp_valid;
  logic [BLK-1:0]  ic_rsp_data;
  logic            dc_req_valid = 1'b0;
  logic [XLEN-1:0] dc_req_addr = '0;
  logic            dc_req_rw = 1'b0;
  logic            dc_req_uncached = 1'b0;
  logic [BLK-1:0]  dc_req_data = '0;
  logic            dc_req_ready;
  logic            dc_rsp_valid;
  logic [BLK-1:0]  dc_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_rw;
  logic            mem_req_uncached;
  logic [BLK-1:0]  mem_req_data;
  logic            mem_rsp_valid = 1'b0;
  logic [BLK-1:0]  mem_rsp_data = '0;

  int errors = 0;
  int checks = 0;

  lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .ic_req_valid_i    (ic_req_valid),
    .ic_req_addr_i     (ic_req_addr),
    .ic_req_ready_o    (ic_req_ready),
    .ic_rsp_valid_o    (ic_rsp_valid),
    .ic_rsp_data_o     (ic_rsp_data),
    .dc_req_valid_i    (dc_req_valid),
    .dc_req_addr_i     (dc_req_addr),
    .dc_req_rw_i       (dc_req_rw),
    .dc_req_uncached_i (dc_req_uncached),
    .dc_req_data_i     (dc_req_data),
    .dc_req_ready_o    (dc_req_ready),
    .dc_rsp_valid_o    (dc_rsp_valid),
    .dc_rsp_data_o     (dc_rsp_data),
    .mem_req_valid_o   (mem_req_valid),
    .mem_req_ready_i   (mem_req_ready),
    .mem_req_addr_o    (mem_req_addr),
    .mem_req_rw_o      (mem_req_rw),
    .mem_req_uncached_o(mem_req_uncached),
    .mem_req_data_o    (mem_req_data),
    .mem_rsp_valid_i   (mem_rsp_valid),
    .mem_rsp_data_i    (mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_busy;       // a transaction has been granted and not answered
  bit              m_offered;    // the request is still waiting for downstream acceptance
  bit              m_owner_ic;
  bit              m_drop;
  int              m_cnt;        // dcache grants in a row while icache waited
  logic [XLEN-1:0] m_addr;
  bit              m_rw, m_unc;
  logic [BLK-1:0]  m_data;
  bit              m_ic_rsp, m_dc_rsp;
  logic [BLK-1:0]  m_ic_data, m_dc_data;
  byte             glog[$];      // grant history, 'I' or 'D'

  function automatic bit icache_wins();
    bit starving;
`ifdef LOWX_ARB_STARVE_GUARD_EN
    starving = (m_cnt == LIMIT);
`else
    starving = 1'b0;
`endif
    return ic_req_valid && (!dc_req_valid || starving);
  endfunction

  function automatic string log_str();
    string s = "";
    foreach (glog[i]) s = $sformatf("%s%c", s, glog[i]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_offered = 0; m_owner_ic = 0; m_drop = 0; m_cnt = 0;
      m_addr = '0; m_rw = 0; m_unc = 0; m_data = '0;
      m_ic_rsp = 0; m_dc_rsp = 0; m_ic_data = '0; m_dc_data = '0;
    end else begin
      m_ic_rsp = 0;
      m_dc_rsp = 0;
      if (!m_busy) begin
        if (!flush && (ic_req_valid || dc_req_valid)) begin
          m_busy = 1; m_offered = 1; m_drop = 0;
          if (icache_wins()) begin
            m_owner_ic = 1; m_addr = ic_req_addr; m_rw = 0; m_unc = 0;
            m_cnt = 0;
            glog.push_back("I");
          end else begin
            m_owner_ic = 0; m_addr = dc_req_addr; m_rw = dc_req_rw;
            m_unc = dc_req_uncached; m_data = dc_req_data;
            m_cnt = ic_req_valid ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            glog.push_back("D");
          end
        end
      end else begin
        if (flush) m_drop = 1;
        if (m_offered) begin
          if (mem_req_ready) m_offered = 0;
        end else if (mem_rsp_valid) begin
          if (m_owner_ic) begin m_ic_data = mem_rsp_data; m_ic_rsp = !m_drop; end
          else            begin m_dc_data = mem_rsp_data; m_dc_rsp = !m_drop; end
          m_busy = 0;
          m_drop = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    bit grant_ok;
    grant_ok = rst_n && !m_busy && !flush;
    check_b("ic_req_ready", ic_req_ready, grant_ok && icache_wins());
    check_b("dc_req_ready", dc_req_ready, grant_ok && dc_req_valid && !icache_wins());
    check_b("mem_req_valid", mem_req_valid, m_offered);
    if (m_offered) begin
      check("mem_req_addr", BLK'(mem_req_addr), BLK'(m_addr));
      check_b("mem_req_rw", mem_req_rw, m_rw);
      check_b("mem_req_uncached", mem_req_uncached, m_unc);
      if (!m_owner_ic) check("mem_req_data", mem_req_data, m_data);
    end
    check_b("ic_rsp_valid", ic_rsp_valid, m_ic_rsp);
    check_b("dc_rsp_valid", dc_rsp_valid, m_dc_rsp);
    if (m_ic_rsp) check("ic_rsp_data", ic_rsp_data, m_ic_data);
    if (m_dc_rsp) check("dc_rsp_data", dc_rsp_data, m_dc_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the offered request after bp stall cycles, respond lat cycles later.
  task automatic serve(input logic [BLK-1:0] d, input int lat, input int bp);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      tick();
      n++;
    end
    if (!mem_req_valid) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: mem_req_valid_o never rose within 50 cycles");
      return;
    end
    repeat (bp) tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (lat - 1) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [BLK-1:0] D_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  initial begin
    string exp_order;

    // Reset state.
    repeat (2) @(negedge clk);
    check_b("reset_mem_valid", mem_req_valid, 1'b0);
    check("reset_mem_addr", BLK'(mem_req_addr), '0);
    check("reset_ic_rsp_data", ic_rsp_data, '0);
    #2 rst_n = 1'b1;
    tick();

    // Single icache read, response three cycles after acceptance.
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h8000_0040;
    @(negedge clk);
    check_b("t1_ic_ready", ic_req_ready, 1'b1);
    tick();
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_b("t1_mem_valid", mem_req_valid, 1'b1);
    check("t1_mem_addr", BLK'(mem_req_addr), BLK'(32'h8000_0040));
    check_b("t1_mem_rw", mem_req_rw, 1'b0);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_b("t1_mem_valid_drop", mem_req_valid, 1'b0);
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = D_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_b("t1_ic_rsp_valid", ic_rsp_valid, 1'b1);
    check("t1_ic_rsp_data", ic_rsp_data, D_BEEF);
    check_b("t1_dc_rsp_valid", dc_rsp_valid, 1'b0);
    tick();
    @(negedge clk);
    check_b("t1_ic_rsp_pulse_end", ic_rsp_valid, 1'b0);
    tick();

    // Simultaneous requests: dcache first, icache in the response+1 cycle.
    glog.delete();
    ic_req_valid = 1'b1; ic_req_addr = 32'h100;
    dc_req_valid = 1'b1; dc_req_addr = 32'h200; dc_req_rw = 1'b1;
    dc_req_data  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    @(negedge clk);
    check_b("t2_dc_ready", dc_req_ready, 1'b1);
    check_b("t2_ic_ready", ic_req_ready, 1'b0);
    tick();
    dc_req_valid = 1'b0;
    @(negedge clk);
    check("t2_mem_addr", BLK'(mem_req_addr), BLK'(32'h200));
    check_b("t2_mem_rw", mem_req_rw, 1'b1);
    tick();
    serve(128'hA5, 2, 0);
    @(negedge clk);
    check_b("t2_ic_ready_after_rsp", ic_req_ready, 1'b1);
    check_b("t2_dc_rsp_valid", dc_rsp_valid, 1'b1);
    tick();
    ic_req_valid = 1'b0;
    serve(128'h5A, 1, 0);
    @(negedge clk);
    check("t2_ic_rsp_data", ic_rsp_data, 128'h5A);
    check_s("t2_grant_order", log_str(), "DI");
    tick();

    // Backpressure: five stalled cycles hold the request; no second grant.
    glog.delete();
    dc_req_valid = 1'b1; dc_req_addr = 32'h300; dc_req_rw = 1'b0; dc_req_uncached = 1'b1;
    @(negedge clk);
    check_b("t3_dc_ready", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 1'b0; dc_req_uncached = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_b("t3_stall_valid", mem_req_valid, 1'b1);
      check("t3_stall_addr", BLK'(mem_req_addr), BLK'(32'h300));
      check_b("t3_stall_uncached", mem_req_uncached, 1'b1);
      check_b("t3_no_ic_grant", ic_req_ready, 1'b0);
      tick();
    end
    serve(128'h33, 1, 0);
    tick();
    ic_req_valid = 1'b0;
    serve(128'h44, 1, 0);
    check_s("t3_grant_order", log_str(), "DI");

    // Flush: blocks a grant in IDLE, and cancels a response in WAIT.
    dc_req_valid = 1'b1; dc_req_addr = 32'h500; flush = 1'b1;
    @(negedge clk);
    check_b("t4_flush_blocks_grant", dc_req_ready, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_b("t4_grant_after_flush", dc_req_ready, 1'b1);
    tick();
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 128'hBAD;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_b("t4_dropped_rsp", dc_rsp_valid, 1'b0);
    tick();
    dc_req_valid = 1'b1; dc_req_addr = 32'h600;
    @(negedge clk);
    check_b("t4_next_grant", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 1'b0;
    serve(128'h600D, 2, 1);
    @(negedge clk);
    check_b("t4_next_rsp_valid", dc_rsp_valid, 1'b1);
    check("t4_next_rsp_data", dc_rsp_data, 128'h600D);
    tick();

    // Both requesters permanently valid: starvation behaviour.
    glog.delete();
    ic_req_valid = 1'b1; ic_req_addr = 32'h700;
    dc_req_valid = 1'b1; dc_req_addr = 32'h800; dc_req_rw = 1'b0;
    for (int i = 0; i < 6; i++) serve(BLK'(i + 1), 1, 0);
    dc_req_valid = 1'b0;
`ifdef LOWX_ARB_STARVE_GUARD_EN
    exp_order = "DDDDID";
`else
    exp_order = "DDDDDD";
`endif
    check_s("t5_grant_order", log_str(), exp_order);
    @(negedge clk);
    check_b("t5_ic_ready_when_dc_idle", ic_req_ready, 1'b1);
    tick();
    ic_req_valid = 1'b0;
    serve(128'h77, 1, 0);
    tick();

    // Asynchronous reset while a request is offered downstream.
    dc_req_valid = 1'b1; dc_req_addr = 32'h900;
    tick();
    dc_req_valid = 1'b0;
    @(negedge clk);
    check_b("t6_in_req", mem_req_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_b("t6_async_valid_low", mem_req_valid, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_b("t6_post_mem_valid", mem_req_valid, 1'b0);
    check("t6_post_mem_addr", BLK'(mem_req_addr), '0);
    check_b("t6_post_ic_ready", ic_req_ready, 1'b0);
    check_b("t6_post_dc_ready", dc_req_ready, 1'b0);
    check("t6_post_ic_rsp_data", ic_rsp_data, '0);
    check("t6_post_dc_rsp_data", dc_rsp_data, '0);
    tick();
    dc_req_valid = 1'b1; dc_req_addr = 32'hA00;
    @(negedge clk);
    check_b("t6_grant_after_reset", dc_req_ready, 1'b1);
    tick();
    dc_req_valid = 1'b0;
    serve(128'hA0, 1, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
